// File: rtl/periph_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-style read path (AR + R) among NUM_M masters.
// Optional R-stall watchdog with ERR/DRAIN recovery under `PERIPH_RD_ARB_TIMEOUT_EN.
module periph_rd_arbiter #(
  parameter  int NUM_M          = 2,
  parameter  int AR_W           = 44,
  parameter  int R_W            = 39,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int GW             = $clog2(NUM_M)
) (
  input  logic                    clk,
  input  logic                    reset_bar,
  input  logic [NUM_M-1:0]        m_ar_valid,
  output logic [NUM_M-1:0]        m_ar_ready,
  input  logic [NUM_M*AR_W-1:0]   m_ar_msg,
  output logic [NUM_M-1:0]        m_r_valid,
  input  logic [NUM_M-1:0]        m_r_ready,
  output logic [R_W-1:0]          m_r_msg,
  output logic                    s_ar_valid,
  input  logic                    s_ar_ready,
  output logic [AR_W-1:0]         s_ar_msg,
  input  logic                    s_r_valid,
  output logic                    s_r_ready,
  input  logic [R_W-1:0]          s_r_msg,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, DRAIN} state_t;

  state_t          state;
  logic [GW-1:0]   grant, last_grant, next_grant, idx;
  logic            any_req;
  logic [AR_W-1:0] ar_msg_arr [NUM_M];

  for (genvar i = 0; i < NUM_M; i++) begin : g_ar_unpack
    assign ar_msg_arr[i] = m_ar_msg[i*AR_W +: AR_W];
  end

  // Search downward so the requester closest after last_grant is written last and wins.
  always_comb begin
    next_grant = last_grant;
    any_req    = 1'b0;
    idx        = '0;
    for (int k = NUM_M; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % NUM_M);
      if (m_ar_valid[idx]) begin
        next_grant = idx;
        any_req    = 1'b1;
      end
    end
  end

  // Messages are routed combinationally; only state and grant are registered.
  always_comb begin
    m_ar_ready = '0;
    m_r_valid  = '0;
    m_r_msg    = '0;
    s_ar_valid = 1'b0;
    s_ar_msg   = '0;
    s_r_ready  = 1'b0;
    case (state)
      ADDR: begin
        s_ar_valid        = m_ar_valid[grant];
        s_ar_msg          = ar_msg_arr[grant];
        m_ar_ready[grant] = s_ar_ready;
      end
      DATA: begin
        m_r_valid[grant] = s_r_valid;
        m_r_msg          = s_r_msg;
        s_r_ready        = m_r_ready[grant];
      end
`ifdef PERIPH_RD_ARB_TIMEOUT_EN
      ERR: begin
        m_r_valid[grant] = 1'b1;
        m_r_msg          = R_W'(3'b101);
      end
      DRAIN: s_r_ready = 1'b1;
`endif
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign grant_id = grant;

`ifdef PERIPH_RD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_M - 1);
`ifdef PERIPH_RD_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant <= next_grant;
          state <= ADDR;
        end
        ADDR: if (s_ar_valid && s_ar_ready) begin
          state <= DATA;
`ifdef PERIPH_RD_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        DATA: begin
          if (s_r_valid && s_r_ready) begin
            if (s_r_msg[0]) begin
              last_grant <= grant;
              state      <= IDLE;
            end
`ifdef PERIPH_RD_ARB_TIMEOUT_EN
            cnt <= '0;
          end else begin
            // ERR is entered on the edge where the stall count reaches TIMEOUT_CYCLES.
            cnt <= cnt + 1'b1;
            if (cnt == CW'(TIMEOUT_CYCLES - 1)) state <= ERR;
`endif
          end
        end
`ifdef PERIPH_RD_ARB_TIMEOUT_EN
        ERR: if (m_r_ready[grant]) state <= DRAIN;
        DRAIN: if (s_r_valid && s_r_msg[0]) begin
          last_grant <= grant;
          state      <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_rd_arbiter.sv
// Scoreboard bench for periph_rd_arbiter: main process drives masters/slave and
// queues expectations; a monitor pops and compares on every AR and R handshake.
module tb_periph_rd_arbiter;
  localparam int NUM_M = 2, AR_W = 44, R_W = 39, TO = 16, GW = 1;

  logic                  clk = 1'b0;
  logic                  reset_bar;
  logic [NUM_M-1:0]      m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [NUM_M*AR_W-1:0] m_ar_msg;
  logic [R_W-1:0]        m_r_msg, s_r_msg;
  logic                  s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, busy;
  logic [AR_W-1:0]       s_ar_msg;
  logic [GW-1:0]         grant_id;

  int passed = 0, total = 0;

  typedef struct packed {logic [2:0] m; logic [63:0] msg;} exp_t;
  exp_t ar_q[$], r_q[$];

  always #5 clk = ~clk;

  periph_rd_arbiter #(.NUM_M(NUM_M), .AR_W(AR_W), .R_W(R_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_bar(reset_bar),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_msg(m_ar_msg),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_msg(m_r_msg),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_msg(s_ar_msg),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_msg(s_r_msg),
    .grant_id(grant_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    total++;
    $display("FAIL %s: handshake not seen within cycle budget", name);
  endtask

  function automatic exp_t mk_e(input int m, input logic [63:0] msg);
    exp_t e;
    e.m = 3'(m);
    e.msg = msg;
    return e;
  endfunction

  function automatic logic [R_W-1:0] mk_r(input logic [35:0] d, input logic [1:0] resp, input logic last);
    return {d, resp, last};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an AR or R handshake, then steps past the edge that completes it.
  task automatic wait_hs(input bit is_ar);
    int n = 0;
    @(negedge clk);
    while (!(is_ar ? (s_ar_valid && s_ar_ready) : (s_r_valid && s_r_ready)) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      if (is_ar) bound_fail("ar_wait");
      else bound_fail("r_wait");
    end
    step();
  endtask

  task automatic run_txn(input int m, input logic [AR_W-1:0] msg, input int nb,
                         input logic [NUM_M-1:0] drop);
    ar_q.push_back(mk_e(m, 64'(msg)));
    wait_hs(1'b1);
    m_ar_valid = m_ar_valid & ~drop;
    for (int b = 0; b < nb; b++) begin
      s_r_msg   = mk_r(36'(msg) + 36'(b), 2'b00, b == nb - 1);
      s_r_valid = 1'b1;
      r_q.push_back(mk_e(m, 64'(s_r_msg)));
      wait_hs(1'b0);
    end
    s_r_valid = 1'b0;
    @(negedge clk);
    chk("busy_fall", 64'(busy), 64'(0));
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_bar) begin
        if (s_ar_valid && s_ar_ready) begin
          if (ar_q.size() == 0) bound_fail("ar_unexpected");
          else begin
            e = ar_q.pop_front();
            chk("ar_grant", 64'(grant_id), 64'(e.m));
            chk("ar_msg", 64'(s_ar_msg), e.msg);
            chk("ar_ready_onehot", 64'(m_ar_ready), 64'(1) << e.m);
          end
        end
        if (|(m_r_valid & m_r_ready)) begin
          if (r_q.size() == 0) bound_fail("r_unexpected");
          else begin
            e = r_q.pop_front();
            chk("r_route", 64'(m_r_valid), 64'(1) << e.m);
            chk("r_msg", 64'(m_r_msg), e.msg);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_bar  = 1'b1;
    m_ar_valid = 2'b11;
    m_r_ready  = '1;
    m_ar_msg   = '0;
    s_ar_ready = 1'b1;
    s_r_valid  = 1'b1;
    s_r_msg    = mk_r(36'hABC, 2'b00, 1'b1);
    #2 reset_bar = 1'b0;

    // Reset: outputs zero despite active inputs
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({m_ar_ready, m_r_valid, s_ar_valid, s_r_ready, busy, grant_id}), 64'(0));
    chk("reset_msgs", 64'(m_r_msg) | 64'(s_ar_msg), 64'(0));
    step();
    m_ar_valid = '0;
    s_r_valid  = 1'b0;
    reset_bar  = 1'b1;
    step();

    // Single master, 4 beats, 1-cycle request-to-AR latency
    m_ar_msg[0 +: AR_W] = 44'h123;
    s_ar_ready = 1'b0;
    m_ar_valid = 2'b01;
    @(negedge clk);
    chk("ar_lat_idle", 64'(s_ar_valid), 64'(0));
    step();
    @(negedge clk);
    chk("ar_lat_addr", 64'({s_ar_valid, s_ar_msg, busy}), 64'({1'b1, 44'h123, 1'b1}));
    step();
    s_ar_ready = 1'b1;
    run_txn(0, 44'h123, 4, 2'b01);

    // Slave R beat while IDLE is refused
    step();
    s_r_msg   = mk_r(36'h5A5, 2'b00, 1'b1);
    s_r_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_inject", 64'({s_r_ready, m_r_valid, busy}), 64'(0));
      step();
    end
    s_r_valid = 1'b0;

    // AR stall: master 1 held off by slave for 5 cycles
    s_ar_ready = 1'b0;
    m_ar_msg[AR_W +: AR_W] = 44'hBEEF1;
    m_ar_valid = 2'b10;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ar_stall", 64'({s_ar_valid, s_ar_msg, m_ar_ready, busy, s_r_ready, grant_id}),
          64'({1'b1, 44'hBEEF1, 2'b00, 1'b1, 1'b0, 1'b1}));
      step();
    end
    s_ar_ready = 1'b1;
    run_txn(1, 44'hBEEF1, 2, 2'b10);

    // Both masters request continuously: rotation 0,1,0,1
    step();
    m_ar_msg   = {44'hA1, 44'hA0};
    m_ar_valid = 2'b11;
    run_txn(0, 44'hA0, 1, 2'b00);
    run_txn(1, 44'hA1, 1, 2'b00);
    run_txn(0, 44'hA0, 1, 2'b00);
    run_txn(1, 44'hA1, 1, 2'b11);

    // Reset mid-read: master 1 in flight after master 0 was last served
    step();
    m_ar_msg   = {44'h88, 44'h77};
    m_ar_valid = 2'b01;
    run_txn(0, 44'h77, 1, 2'b01);
    step();
    m_ar_valid = 2'b10;
    ar_q.push_back(mk_e(1, 64'(44'h88)));
    wait_hs(1'b1);
    m_ar_valid = '0;
    s_r_msg    = mk_r(36'h1, 2'b00, 1'b0);
    s_r_valid  = 1'b1;
    r_q.push_back(mk_e(1, 64'(s_r_msg)));
    wait_hs(1'b0);
    s_r_msg = mk_r(36'h2, 2'b00, 1'b0);
    #1;
    chk("beat2_routed", 64'({m_r_valid, s_r_ready, busy}), 64'({2'b10, 1'b1, 1'b1}));
    reset_bar = 1'b0;
    #1;
    chk("reset_async", 64'({m_ar_ready, m_r_valid, s_ar_valid, s_r_ready, busy, grant_id}), 64'(0));
    chk("reset_async_msg", 64'(m_r_msg), 64'(0));
    s_r_valid  = 1'b0;
    m_ar_valid = 2'b11;
    step();
    step();
    reset_bar = 1'b1;
    run_txn(0, 44'h77, 1, 2'b11);

`ifdef PERIPH_RD_ARB_TIMEOUT_EN
    // Silent slave: error beat after TO cycles, then late beats are drained
    step();
    m_ar_valid = 2'b01;
    ar_q.push_back(mk_e(0, 64'(44'h77)));
    wait_hs(1'b1);
    m_ar_valid = '0;
    r_q.push_back(mk_e(0, 64'(mk_r(36'h0, 2'b10, 1'b1))));
    n = 0;
    @(negedge clk);
    while (!m_r_valid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'(TO));
    step();
    for (int b = 0; b < 2; b++) begin
      s_r_msg   = mk_r(36'hD0 + 36'(b), 2'b00, b == 1);
      s_r_valid = 1'b1;
      @(negedge clk);
      chk("drain", 64'({m_r_valid, s_r_ready, busy}), 64'({2'b00, 1'b1, 1'b1}));
      step();
    end
    s_r_valid = 1'b0;
    @(negedge clk);
    chk("drain_exit", 64'(busy), 64'(0));
`endif

    repeat (3) step();
    chk("ar_q_empty", 64'(ar_q.size()), 64'(0));
    chk("r_q_empty", 64'(r_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/periph_rd_arbiter.md
Name: periph_rd_arbiter

Overview:
- Shares one peripheral AXI-style read path (AR and R valid/ready/msg channels) between NUM_M requesting masters.
- Sits between the CPU-side and accelerator-side read masters and the SystemC subsystem wrapper's ar/r ports.
- Round-robin arbitration; one read transaction (AR plus all R beats) is in flight at a time.

Parameters:
- NUM_M, 2, number of requesting masters (2..8)
- AR_W, 44, AR message width
- R_W, 39, R message width; bit 0 = last, bits [2:1] = resp
- TIMEOUT_CYCLES, 1024, R-stall watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset_bar  in  1  asynchronous active-low reset
- m_ar_valid  in  NUM_M  per-master AR valid
- m_ar_ready  out  NUM_M  per-master AR ready
- m_ar_msg  in  NUM_M*AR_W  packed AR messages; master i occupies [i*AR_W +: AR_W]
- m_r_valid  out  NUM_M  per-master R valid
- m_r_ready  in  NUM_M  per-master R ready
- m_r_msg  out  R_W  R message, broadcast to all masters
- s_ar_valid  out  1  slave AR valid
- s_ar_ready  in  1  slave AR ready
- s_ar_msg  out  AR_W  slave AR message
- s_r_valid  in  1  slave R valid
- s_r_ready  out  1  slave R ready
- s_r_msg  in  R_W  slave R message
- grant_id  out  $clog2(NUM_M)  index of the current owner; valid while busy=1
- busy  out  1  high in every state except IDLE

Behaviour:
- Single clock domain: clk. Reset: reset_bar, asynchronous assert, active-low. Reset leaves state=IDLE and last_grant=NUM_M-1, so master 0 wins first. All outputs are 0 during and after reset.
- FSM states: IDLE, ADDR, DATA (plus ERR and DRAIN when the optional feature is compiled in).
- IDLE:
  - m_ar_ready=0, s_ar_valid=0, s_r_ready=0.
  - If any m_ar_valid is high, grant the first requester found searching from last_grant+1 upward, modulo NUM_M.
  - Register the winner in grant, then go to ADDR.
- ADDR:
  - s_ar_valid=m_ar_valid[grant]; s_ar_msg=m_ar_msg[grant]; m_ar_ready[grant]=s_ar_ready; all other m_ar_ready=0.
  - Go to DATA on s_ar_valid && s_ar_ready.
  - Latency: m_ar_valid high to s_ar_valid high is exactly 1 cycle.
- DATA:
  - m_r_valid[grant]=s_r_valid; other m_r_valid=0; m_r_msg=s_r_msg; s_r_ready=m_r_ready[grant].
  - On a handshake with s_r_msg[0]=1, set last_grant=grant and go to IDLE.
  - A new arbitration happens on the next cycle, so there is 1 idle cycle between transactions.
- The arbiter adds no pipeline registers on AR or R data: messages pass combinationally, only control is registered.
- Slave protocol violations:
  - s_r_valid in IDLE or ADDR is not accepted (s_r_ready=0).
  - s_ar_ready outside ADDR is ignored.
- Requester behaviour:
  - A master dropping m_ar_valid while in ADDR keeps the grant; the arbiter waits.
  - Other masters' requests are held off (ready=0) until the current transaction returns to IDLE.
- Simultaneous requests from all masters are served in strict rotation: 0,1,...,NUM_M-1,0.

Optional Feature:
- Macro: PERIPH_RD_ARB_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(TIMEOUT_CYCLES)+1) clears on entering DATA and on every R handshake, and increments each DATA cycle with no handshake.
  - When it reaches TIMEOUT_CYCLES, go to ERR.
  - ERR: m_r_valid[grant]=1; m_r_msg = all zero except resp=2'b10 and last=1; s_r_ready=0. On m_r_ready[grant], go to DRAIN.
  - DRAIN: s_r_ready=1; all m_r_valid=0; discard beats. Leave for IDLE (last_grant=grant) on a beat with last=1. DRAIN has no timeout.
- Undefined: no counter, no ERR/DRAIN states; DATA waits indefinitely.

Test Plan:
- Reset, then only master 0 requests with AR msg 44'h123 and slave returns 4 beats, last on beat 4 -> s_ar_valid rises 1 cycle after request with s_ar_msg=44'h123; 4 beats routed to m_r_valid[0] only; busy falls the cycle after the last beat.
- Masters 0 and 1 request continuously with single-beat reads -> grant_id sequence 0,1,0,1; m_ar_ready never high for both in the same cycle.
- Slave holds s_ar_ready=0 for 5 cycles -> s_ar_valid and s_ar_msg stay stable, m_ar_ready[grant]=0 for those 5 cycles, no transition to DATA.
- reset_bar asserted during beat 2 of a 4-beat read -> outputs go 0 immediately; after release, master 0 wins first again.
- Slave injects s_r_valid while IDLE -> s_r_ready=0, no m_r_valid asserted.
- With PERIPH_RD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave silent after AR -> m_r_valid[grant] high 16 cycles after entering DATA with resp=2'b10 and last=1; a later slave 2-beat response is discarded in DRAIN, then the arbiter returns to IDLE.
